// File: rtl/ram_console_pkg.sv
// Shared types and constants for the RAM switch console: preload pattern and FSM states.
package ram_console_pkg;

  localparam int INIT_WORDS = 4;

  localparam logic [15:0] INIT_PAT [INIT_WORDS] = '{
    16'h00FF, 16'h0F0F, 16'h3333, 16'h5555
  };

  typedef enum logic [1:0] {
    ST_INIT,
    ST_IDLE,
    ST_CLEAR
  } state_e;

endpackage

// File: rtl/ram_switch_console_btn_pulse.sv
// Pushbutton front-end: synchroniser chain plus debounce counter.
// Emits a one-cycle press pulse, then re-arms only after a long enough low period.
module btn_pulse #(
  parameter int SYNC_STAGES  = 2,
  parameter int DEBOUNCE_CYC = 250000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic press
);

  localparam int CW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYC - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          cnt_q;
  logic                   held_q;
  logic                   press_q;
  logic                   btn_s;

  assign btn_s = sync_q[SYNC_STAGES-1];
  assign press = press_q;

  // held_q marks an accepted press; the counter then measures the low time needed to re-arm
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      held_q  <= 1'b0;
      press_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], btn_raw};
      press_q <= 1'b0;
      if (btn_s == held_q) begin
        cnt_q <= '0;
      end else if (cnt_q == LAST) begin
        cnt_q   <= '0;
        held_q  <= btn_s;
        press_q <= btn_s;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

endmodule

// File: rtl/ram_switch_console.sv
// Switch/button console for a single-port RAM: address latch, write with auto-increment,
// clear sweep, pattern preload after reset and a write-first registered read.
module ram_switch_console
  import ram_console_pkg::*;
#(
  parameter int DATA_W       = 16,
  parameter int ADDR_W       = 10,
  parameter bit AUTO_INC     = 1'b1,
  parameter int DEBOUNCE_CYC = 250000,
  parameter int SYNC_STAGES  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] sw,
  input  logic              btn_addr,
  input  logic              btn_write,
  input  logic              btn_next,
  input  logic              btn_clear,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              busy,
  output logic              wrap
);

  localparam int DEPTH = 2 ** ADDR_W;

  state_e            state_q;
  logic [ADDR_W-1:0] out_addr_q;
  logic [DATA_W-1:0] out_data_q;
  logic              busy_q;
  logic              wrap_q;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              ev_addr, ev_write, ev_next, ev_clear;
  logic [ADDR_W-1:0] addr_inc;
  logic              at_top;
  logic              we;
  logic [DATA_W-1:0] wdata;

  btn_pulse #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYC(DEBOUNCE_CYC)) u_btn_addr (
    .clk(clk), .rst_n(rst_n), .btn_raw(btn_addr), .press(ev_addr));
  btn_pulse #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYC(DEBOUNCE_CYC)) u_btn_write (
    .clk(clk), .rst_n(rst_n), .btn_raw(btn_write), .press(ev_write));
  btn_pulse #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYC(DEBOUNCE_CYC)) u_btn_next (
    .clk(clk), .rst_n(rst_n), .btn_raw(btn_next), .press(ev_next));
  btn_pulse #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYC(DEBOUNCE_CYC)) u_btn_clear (
    .clk(clk), .rst_n(rst_n), .btn_raw(btn_clear), .press(ev_clear));

  assign addr_inc = out_addr_q + ADDR_W'(1);
  assign at_top   = &out_addr_q;

  // Single write port: the sweeps reuse out_addr_q as their address counter
  always_comb begin
    we    = 1'b0;
    wdata = sw;
    case (state_q)
      ST_INIT: begin
        we    = 1'b1;
        wdata = DATA_W'(INIT_PAT[out_addr_q[1:0]]);
      end
      ST_CLEAR: begin
        we    = 1'b1;
        wdata = '0;
      end
      default: we = ev_write && !ev_clear && !ev_addr;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_INIT;
      out_addr_q <= '0;
      busy_q     <= 1'b1;
      wrap_q     <= 1'b0;
    end else begin
      wrap_q <= 1'b0;
      case (state_q)
        ST_INIT: begin
          if (out_addr_q == ADDR_W'(INIT_WORDS - 1)) begin
            state_q    <= ST_IDLE;
            out_addr_q <= '0;
            busy_q     <= 1'b0;
          end else begin
            out_addr_q <= addr_inc;
          end
        end
        ST_CLEAR: begin
          out_addr_q <= addr_inc;
          if (at_top) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          if (ev_clear) begin
            state_q    <= ST_CLEAR;
            out_addr_q <= '0;
            busy_q     <= 1'b1;
          end else if (ev_addr) begin
            out_addr_q <= sw[ADDR_W-1:0];
          end else if (ev_write) begin
            if (AUTO_INC) begin
              out_addr_q <= addr_inc;
              wrap_q     <= at_top;
            end
          end else if (ev_next) begin
            out_addr_q <= addr_inc;
            wrap_q     <= at_top;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem_q[out_addr_q] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) out_data_q <= '0;
    else        out_data_q <= we ? wdata : mem_q[out_addr_q];
  end

  assign out_data = out_data_q;
  assign out_addr = out_addr_q;
  assign busy     = busy_q;
  assign wrap     = wrap_q;

endmodule

// File: tb/tb_ram_switch_console.sv
// Directed bench for ram_switch_console with a short debounce time.
module tb_ram_switch_console;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 10;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [DATA_W-1:0] sw;
  logic              btn_addr, btn_write, btn_next, btn_clear;
  logic [DATA_W-1:0] out_data;
  logic [ADDR_W-1:0] out_addr;
  logic              busy, wrap;

  int vectors = 0;
  int miscompares = 0;
  int wrap_cnt = 0;
  int n;

  always #5 clk = ~clk;

  ram_switch_console #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .AUTO_INC(1'b1),
    .DEBOUNCE_CYC(4), .SYNC_STAGES(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sw(sw),
    .btn_addr(btn_addr), .btn_write(btn_write), .btn_next(btn_next), .btn_clear(btn_clear),
    .out_data(out_data), .out_addr(out_addr), .busy(busy), .wrap(wrap)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (wrap === 1'b1) wrap_cnt++;
  endtask

  task automatic set_btn(input int which, input logic v);
    case (which)
      0:       btn_addr  = v;
      1:       btn_write = v;
      2:       btn_next  = v;
      default: btn_clear = v;
    endcase
  endtask

  task automatic press(input int which);
    set_btn(which, 1'b1);
    repeat (10) tick();
    set_btn(which, 1'b0);
    repeat (10) tick();
  endtask

  task automatic latch(input int a);
    sw = 16'(a);
    press(0);
  endtask

  task automatic count_busy(input int lim, output int cnt);
    cnt = 0;
    while (busy === 1'b1 && cnt < lim) begin
      cnt++;
      tick();
    end
  endtask

  initial begin
    logic [15:0] pat [4];
    int          clr_addrs [5];
    pat       = '{16'h00FF, 16'h0F0F, 16'h3333, 16'h5555};
    clr_addrs = '{1, 2, 5, 500, 1023};

    rst_n = 1'b0; sw = '0;
    btn_addr = 1'b0; btn_write = 1'b0; btn_next = 1'b0; btn_clear = 1'b0;
    repeat (3) @(negedge clk);
    check("rst busy", 32'(busy), 32'h1);
    check("rst out_addr", 32'(out_addr), 32'h0);
    check("rst out_data", 32'(out_data), 32'h0);
    check("rst wrap", 32'(wrap), 32'h0);

    rst_n = 1'b1;
    count_busy(100, n);
    check("init busy cycles", 32'(n), 32'd4);
    check("init out_addr", 32'(out_addr), 32'h0);

    // 1: latch address 2, data follows one cycle after the address
    sw = 16'd2; btn_addr = 1'b1;
    n = 0;
    while (out_addr !== 10'd2 && n < 50) begin n++; tick(); end
    check("t1 out_addr", 32'(out_addr), 32'd2);
    check("t1 data before", 32'(out_data), 32'h00FF);
    tick();
    check("t1 data after", 32'(out_data), 32'h3333);
    btn_addr = 1'b0;
    repeat (10) tick();

    // 2: write with auto-increment
    latch(5);
    sw = 16'hBEEF; press(1);
    check("t2 out_addr inc", 32'(out_addr), 32'd6);
    latch(5);
    check("t2 readback", 32'(out_data), 32'hBEEF);

    // 3: wrap from the top address via write and via next
    latch(1023);
    wrap_cnt = 0; press(1);
    check("t3 write wrap addr", 32'(out_addr), 32'd0);
    check("t3 write wrap pulses", 32'(wrap_cnt), 32'd1);
    latch(1023);
    check("t3 mem1023", 32'(out_data), 32'h03FF);
    wrap_cnt = 0; press(2);
    check("t3 next wrap addr", 32'(out_addr), 32'd0);
    check("t3 next wrap pulses", 32'(wrap_cnt), 32'd1);

    // 4: short glitches ignored, long hold gives exactly one write
    latch(10);
    sw = 16'hA5A5;
    repeat (3) begin
      btn_write = 1'b1; repeat (3) tick();
      btn_write = 1'b0; repeat (6) tick();
    end
    check("t4 glitch no inc", 32'(out_addr), 32'd10);
    btn_write = 1'b1; repeat (20) tick();
    btn_write = 1'b0; repeat (10) tick();
    check("t4 one inc", 32'(out_addr), 32'd11);
    latch(10);
    check("t4 one write", 32'(out_data), 32'hA5A5);

    // 5: clear sweep, write button during sweep is discarded
    btn_clear = 1'b1;
    n = 0;
    while (busy !== 1'b1 && n < 50) begin n++; tick(); end
    btn_clear = 1'b0;
    check("t5 busy start", 32'(busy), 32'h1);
    wrap_cnt = 0;
    n = 0;
    while (busy === 1'b1 && n < 2000) begin
      if (n == 100) begin sw = 16'hFFFF; btn_write = 1'b1; end
      if (n == 130) btn_write = 1'b0;
      n++;
      tick();
    end
    check("t5 busy cycles", 32'(n), 32'd1024);
    check("t5 no wrap", 32'(wrap_cnt), 32'd0);
    check("t5 out_addr", 32'(out_addr), 32'd0);
    check("t5 data addr0", 32'(out_data), 32'd0);
    repeat (10) tick();
    check("t5 write dropped", 32'(out_addr), 32'd0);
    foreach (clr_addrs[i]) begin
      latch(clr_addrs[i]);
      check($sformatf("t5 cleared %0d", clr_addrs[i]), 32'(out_data), 32'd0);
    end

    // 6: reset in the middle of a clear sweep
    latch(500);
    sw = 16'h1234; press(1);
    btn_clear = 1'b1;
    n = 0;
    while (busy !== 1'b1 && n < 50) begin n++; tick(); end
    btn_clear = 1'b0;
    repeat (300) tick();
    rst_n = 1'b0;
    repeat (2) tick();
    check("t6 rst busy", 32'(busy), 32'h1);
    check("t6 rst out_addr", 32'(out_addr), 32'd0);
    check("t6 rst out_data", 32'(out_data), 32'd0);
    rst_n = 1'b1;
    count_busy(100, n);
    check("t6 init busy cycles", 32'(n), 32'd4);
    for (int a = 0; a < 4; a++) begin
      latch(a);
      check($sformatf("t6 pattern %0d", a), 32'(out_data), 32'(pat[a]));
    end
    latch(500);
    check("t6 addr500 kept", 32'(out_data), 32'h1234);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
